aq_cjpeg_bitpack: RTL and testbench
===================================

# aq_cjpeg_bitpack

Entropy-coded bitstream packer for the JPEG encoder path, the transmit-side counterpart of the decoder's bitstream register stage. It accepts variable-length Huffman/amplitude codes (1–32 bits), packs them MSB-first into bytes, and inserts a 0x00 byte after every 0xFF data byte. It also inserts raw (unstuffed) 16-bit markers and pads the last byte with 1s at end of scan. It emits 32-bit words with the first stream byte in bits [7:0], the same byte order the decoder's input expects.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- BitIn  in  32  code bits, right-aligned; bit BitWidth-1 is sent first
- BitWidth  in  6  number of valid bits, 0..32; 0 = accepted no-op
- BitEnable  in  1  code valid; transfers when BitEnable & BitReady
- BitReady  out  1  packer can accept a code, marker or flush this cycle
- MarkerEnable  in  1  request to insert Marker; transfers when MarkerEnable & BitReady
- Marker  in  16  marker bytes, [15:8] sent first (e.g. 16'hFFD9)
- Flush  in  1  end-of-stream request; transfers when Flush & BitReady
- DataOut  out  32  packed word; byte0 (earliest) in [7:0]
- DataOutEnable  out  1  DataOut valid; held until taken
- DataOutReady  in  1  consumer takes the word when DataOutEnable & DataOutReady
- DataOutLast  out  1  qualifies final word of the stream
- DataOutBytes  out  3  valid bytes in DataOut, 1..4
- Busy  out  1  a marker or flush sequence is in progress, or data is still pending

## Operation
- **Accumulator.** AccReg is 64 bits wide; AccWidth is 0..64.
  - An accepted code appends BitWidth bits below the current content.
  - BitReady = (State==RUN) & (AccWidth <= 32).
  - Only one of BitEnable, MarkerEnable or Flush is asserted per cycle. Priority if violated: Flush > MarkerEnable > BitEnable; the others are dropped.
- **Byte stage.** Each cycle, if AccWidth >= 8, no stuff byte is pending and the word assembler can accept, it pops the top 8 bits and sends the byte to the assembler.
  - If the popped data byte == 0xFF, StuffPending is set. The next slot sends 0x00 and clears StuffPending.
  - A code append and a byte pop may happen in the same cycle. The new width is AccWidth + BitWidth - 8.
- **Word assembler.** Collects bytes into a 4-byte word at positions [7:0], [15:8], [23:16], [31:24] in order.
  - When it holds 4 bytes it moves them into the output register if that register is empty or is being taken this cycle. Otherwise it stalls, and the stall propagates back to the byte stage and then to BitReady.
- **State machine.**
  - RUN: normal packing.
  - PAD: entered on a marker or flush request. If AccWidth % 8 != 0, append (8 - AccWidth%8) 1-bits. Wait until AccWidth==0 and StuffPending==0.
  - MARK1: after PAD when the request was a marker. Send Marker[15:8] raw, no stuff check, then go to MARK2.
  - MARK2: send Marker[7:0] raw, then return to RUN.
  - FLUSH: after PAD when the request was Flush. Wait for the output register to be empty.
  - LAST: emit the assembler's partial word with DataOutLast=1 and DataOutBytes = byte count, unused bytes 0, then return to RUN.
    - If the assembler is empty and the previous word is already gone, emit nothing and return to RUN.
    - If the assembler is exactly full in FLUSH, that word is emitted as the last word with DataOutBytes=4.
- **Busy** = (State != RUN) | (AccWidth != 0) | StuffPending | assembler non-empty | DataOutEnable.

## Timing
- **Reset values:** DataOut=0, DataOutEnable=0, DataOutLast=0, DataOutBytes=0, Busy=0, BitReady=1 (first cycle after rst release), AccWidth=0, State=RUN.
- **Throughput and latency:**
  - Throughput is 1 byte/cycle sustained, including stuff bytes.
  - A code accepted at edge N with AccWidth reaching >= 8 has its first byte popped at edge N+1.
  - A completed 4-byte word is registered one edge after its fourth byte and shows DataOutEnable=1 from that edge.
- **Output register:**
  - Holds DataOut, DataOutLast and DataOutBytes stable while DataOutEnable=1 and DataOutReady=0.
  - Back-to-back words are possible, one per cycle, when DataOutReady is held 1.
- **BitWidth = 32 at AccWidth = 32** fills the accumulator to 64. This is legal; BitReady deasserts until AccWidth <= 32.
- **Reset mid-operation** discards all bits, pending stuff and partial words with no output.
- **Markers:** 0xFF inside a marker is never stuffed. A marker byte of 0xFF never sets StuffPending.

## Test plan
- Reset → all outputs 0, BitReady=1, Busy=0.
- Codes 0x12, 0x34, 0x56, 0x78 (width 8 each, DataOutReady=1) → one word DataOut=0x78563412, DataOutBytes=4, DataOutLast=0, no other output.
- Codes 16'hFFAB then 16'hCDEF, then Flush → words 0xCDAB00FF (Last=0), then 0x000000EF with Last=1 and DataOutBytes=1.
- Code 3'b101 then Flush → single word 0x000000BF, Last=1, Bytes=1 (pad 11111).
- Code 4'h0, Marker 16'hFFD9, Flush → 0x00D9FF0F, Last=1, Bytes=3 (no 0x00 after the marker FF).
- DataOutReady=0 while 40 bytes of 0xFF codes are fed → BitReady drops and DataOut stays stable. Release DataOutReady → 80 bytes in order FF,00 repeated, nothing lost or duplicated.

Source files
------------

// File: rtl/aq_cjpeg_bitpack_if.sv
// Code/marker/flush input side and packed-word output side of the JPEG bitstream packer.
interface aq_cjpeg_bitpack_if;
  logic [31:0] BitIn;
  logic [5:0]  BitWidth;
  logic        BitEnable;
  logic        BitReady;
  logic        MarkerEnable;
  logic [15:0] Marker;
  logic        Flush;
  logic [31:0] DataOut;
  logic        DataOutEnable;
  logic        DataOutReady;
  logic        DataOutLast;
  logic [2:0]  DataOutBytes;
  logic        Busy;

  modport master (
    output BitIn, BitWidth, BitEnable, MarkerEnable, Marker, Flush, DataOutReady,
    input  BitReady, DataOut, DataOutEnable, DataOutLast, DataOutBytes, Busy
  );

  modport slave (
    input  BitIn, BitWidth, BitEnable, MarkerEnable, Marker, Flush, DataOutReady,
    output BitReady, DataOut, DataOutEnable, DataOutLast, DataOutBytes, Busy
  );
endinterface

// File: rtl/aq_cjpeg_bitpack.sv
// Packs 1-32 bit codes MSB-first into 0xFF-stuffed bytes and 32-bit words; 1 byte/cycle, word out one edge after its 4th byte.
// Output stall backs up through the word assembler and byte stage into the accumulator, dropping BitReady once it holds more than 32 bits.
module aq_cjpeg_bitpack (
  input logic clk,
  input logic rst,
  aq_cjpeg_bitpack_if.slave bus
);

  typedef enum logic [2:0] {RUN, PAD, MARK1, MARK2, FLUSH, LAST} state_t;

  state_t      State;
  logic [63:0] AccReg;
  logic [6:0]  AccWidth;
  logic        StuffPending;
  logic        ReqMark;
  logic [15:0] MarkReg;
  logic [31:0] AsmReg;
  logic [2:0]  AsmCount;

  logic        bitReady;
  logic        takeFlush, takeMark, takeCode;
  logic        padDone, flushHold, outFree, outTake;
  logic        asmMove, asmAccept;
  logic        stuffVld, popVld, markVld, byteVld;
  logic [7:0]  byteDat;
  logic        padVld;
  logic [5:0]  appendW;
  logic [31:0] appendCode;
  logic [6:0]  widthAfterPop;
  logic [63:0] accShifted, appendVal;

  assign bitReady  = (State == RUN) && (AccWidth <= 7'd32);
  assign takeFlush = bus.Flush && bitReady;
  assign takeMark  = bus.MarkerEnable && bitReady && !bus.Flush;
  assign takeCode  = bus.BitEnable && bitReady && !bus.Flush && !bus.MarkerEnable;

  assign padDone = (AccWidth == 7'd0) && !StuffPending;
  // A word completed at the very end of a flushed stream is held back so LAST can tag it.
  assign flushHold = (State == FLUSH) || (State == LAST) || ((State == PAD) && !ReqMark && padDone);
  assign outFree   = !bus.DataOutEnable || bus.DataOutReady;
  assign outTake   = bus.DataOutEnable && bus.DataOutReady;
  assign asmMove   = (AsmCount == 3'd4) && outFree && !flushHold;
  assign asmAccept = (AsmCount != 3'd4) || asmMove;

  assign stuffVld = StuffPending && asmAccept;
  assign popVld   = !StuffPending && (AccWidth >= 7'd8) && asmAccept;
  assign markVld  = ((State == MARK1) || (State == MARK2)) && asmAccept;
  assign byteVld  = stuffVld || popVld || markVld;

  always_comb begin
    byteDat = 8'h00;
    if (popVld)
      byteDat = AccReg[63:56];
    else if (markVld)
      byteDat = (State == MARK1) ? MarkReg[15:8] : MarkReg[7:0];
  end

  // Codes and pad bits share one append path; width 0 shifts the value out entirely.
  assign padVld     = (State == PAD) && (AccWidth[2:0] != 3'd0);
  assign appendW    = takeCode ? bus.BitWidth :
                      padVld   ? {2'b00, 4'd8 - {1'b0, AccWidth[2:0]}} : 6'd0;
  assign appendCode = takeCode ? bus.BitIn : 32'hFFFF_FFFF;

  assign widthAfterPop = popVld ? (AccWidth - 7'd8) : AccWidth;
  assign accShifted    = popVld ? {AccReg[55:0], 8'h00} : AccReg;
  assign appendVal     = ({32'h0, appendCode} << (7'd64 - {1'b0, appendW})) >> widthAfterPop;

  assign bus.BitReady = bitReady;
  assign bus.Busy     = (State != RUN) || (AccWidth != 7'd0) || StuffPending ||
                        (AsmCount != 3'd0) || bus.DataOutEnable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      State             <= RUN;
      AccReg            <= 64'h0;
      AccWidth          <= 7'd0;
      StuffPending      <= 1'b0;
      ReqMark           <= 1'b0;
      MarkReg           <= 16'h0;
      AsmReg            <= 32'h0;
      AsmCount          <= 3'd0;
      bus.DataOut       <= 32'h0;
      bus.DataOutEnable <= 1'b0;
      bus.DataOutLast   <= 1'b0;
      bus.DataOutBytes  <= 3'd0;
    end else begin
      AccReg   <= accShifted | appendVal;
      AccWidth <= widthAfterPop + {1'b0, appendW};

      if (stuffVld)
        StuffPending <= 1'b0;
      else if (popVld)
        StuffPending <= (AccReg[63:56] == 8'hFF);

      if (outTake)
        bus.DataOutEnable <= 1'b0;
      if (asmMove) begin
        bus.DataOut       <= AsmReg;
        bus.DataOutEnable <= 1'b1;
        bus.DataOutLast   <= 1'b0;
        bus.DataOutBytes  <= 3'd4;
      end else if ((State == LAST) && (AsmCount != 3'd0)) begin
        bus.DataOut       <= AsmReg;
        bus.DataOutEnable <= 1'b1;
        bus.DataOutLast   <= 1'b1;
        bus.DataOutBytes  <= AsmCount;
      end

      if (asmMove || (State == LAST)) begin
        AsmReg   <= byteVld ? {24'h0, byteDat} : 32'h0;
        AsmCount <= byteVld ? 3'd1 : 3'd0;
      end else if (byteVld) begin
        AsmReg[{AsmCount[1:0], 3'b000} +: 8] <= byteDat;
        AsmCount <= AsmCount + 3'd1;
      end

      case (State)
        RUN: begin
          if (takeFlush) begin
            State   <= PAD;
            ReqMark <= 1'b0;
          end else if (takeMark) begin
            State   <= PAD;
            ReqMark <= 1'b1;
            MarkReg <= bus.Marker;
          end
        end
        PAD:   if (padDone) State <= ReqMark ? MARK1 : FLUSH;
        MARK1: if (asmAccept) State <= MARK2;
        MARK2: if (asmAccept) State <= RUN;
        FLUSH: if (!bus.DataOutEnable) State <= LAST;
        LAST:  State <= RUN;
        default: State <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_aq_cjpeg_bitpack.sv
// Scoreboard bench for aq_cjpeg_bitpack: expected words queued at stimulus time, popped on each output transfer.
module tb_aq_cjpeg_bitpack;

  typedef struct packed {
    logic [31:0] dat;
    logic [2:0]  bytes;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;
  aq_cjpeg_bitpack_if bif();

  aq_cjpeg_bitpack dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  exp_t sbQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, assertions=%0d failures=%0d", assertCount, failCount);
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic pushExp(input logic [31:0] dat, input logic [2:0] bytes, input logic last);
    exp_t e;
    e.dat = dat;
    e.bytes = bytes;
    e.last = last;
    sbQ.push_back(e);
  endtask

  // Output monitor: samples between edges, a transfer happens on the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && bif.DataOutEnable && bif.DataOutReady) begin
        checkVal("wordExpected", sbQ.size() != 0, 1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          checkVal("DataOut", bif.DataOut, e.dat);
          checkVal("DataOutBytes", bif.DataOutBytes, e.bytes);
          checkVal("DataOutLast", bif.DataOutLast, e.last);
        end
      end
    end
  end

  // Every request task starts and ends just after a falling edge.
  task automatic waitReady(input string tag);
    int n = 0;
    while (!bif.BitReady && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) checkVal({tag, "ReadyWait"}, bif.BitReady, 1);
    @(negedge clk);
  endtask

  task automatic sendCode(input logic [31:0] bits, input logic [5:0] width);
    bif.BitIn = bits;
    bif.BitWidth = width;
    bif.BitEnable = 1'b1;
    waitReady("code");
    bif.BitEnable = 1'b0;
  endtask

  task automatic sendMarker(input logic [15:0] mk);
    bif.Marker = mk;
    bif.MarkerEnable = 1'b1;
    waitReady("marker");
    bif.MarkerEnable = 1'b0;
  endtask

  task automatic sendFlush();
    bif.Flush = 1'b1;
    waitReady("flush");
    bif.Flush = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sbQ.size() != 0 || bif.Busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checkVal({tag, "Pending"}, sbQ.size(), 0);
    checkVal({tag, "Busy"}, bif.Busy, 0);
  endtask

  initial begin
    rst = 1'b0;
    bif.BitIn = 32'h0;
    bif.BitWidth = 6'd0;
    bif.BitEnable = 1'b0;
    bif.MarkerEnable = 1'b0;
    bif.Marker = 16'h0;
    bif.Flush = 1'b0;
    bif.DataOutReady = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    checkVal("rstDataOut", bif.DataOut, 32'h0);
    checkVal("rstEnable", bif.DataOutEnable, 0);
    checkVal("rstLast", bif.DataOutLast, 0);
    checkVal("rstBytes", bif.DataOutBytes, 0);
    checkVal("rstBusy", bif.Busy, 0);
    checkVal("rstBitReady", bif.BitReady, 1);

    // Partial data discarded by reset must never appear.
    sendCode(32'h00AB_CDEF, 6'd24);
    checkVal("preRstBusy", bif.Busy, 1);
    rst = 1'b0;
    @(negedge clk);
    checkVal("inRstBusy", bif.Busy, 0);
    checkVal("inRstEnable", bif.DataOutEnable, 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checkVal("postRstBusy", bif.Busy, 0);
    checkVal("postRstReady", bif.BitReady, 1);

    // Four plain bytes, with a width-0 no-op carrying garbage bits in the middle.
    pushExp(32'h7856_3412, 3'd4, 1'b0);
    sendCode(32'h0000_0012, 6'd8);
    sendCode(32'h0000_0034, 6'd8);
    sendCode(32'hDEAD_BEEF, 6'd0);
    sendCode(32'hFFFF_FF56, 6'd8);
    sendCode(32'h0000_0078, 6'd8);
    drain("plain");

    // 0xFF data byte gets a stuffed 0x00; trailing byte flushed as last.
    pushExp(32'hCDAB_00FF, 3'd4, 1'b0);
    pushExp(32'h0000_00EF, 3'd1, 1'b1);
    sendCode(32'h0000_FFAB, 6'd16);
    sendCode(32'h0000_CDEF, 6'd16);
    sendFlush();
    drain("stuff");

    // 3-bit code padded with ones.
    pushExp(32'h0000_00BF, 3'd1, 1'b1);
    sendCode(32'h0000_0005, 6'd3);
    sendFlush();
    drain("pad");

    // Marker FF is sent raw, no stuffing after it.
    pushExp(32'h00D9_FF0F, 3'd3, 1'b1);
    sendCode(32'h0, 6'd4);
    sendMarker(16'hFFD9);
    sendFlush();
    drain("marker");

    // Output stalled while 40 bytes of 0xFF are offered, then released.
    for (int i = 0; i < 20; i++) pushExp(32'h00FF_00FF, 3'd4, 1'b0);
    bif.DataOutReady = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) sendCode(32'hFFFF_FFFF, 6'd32);
      end
      begin
        repeat (60) @(negedge clk);
        checkVal("stallBitReady", bif.BitReady, 0);
        checkVal("stallEnable", bif.DataOutEnable, 1);
        checkVal("stallDataOut", bif.DataOut, 32'h00FF_00FF);
        repeat (10) @(negedge clk);
        checkVal("stallHoldDataOut", bif.DataOut, 32'h00FF_00FF);
        checkVal("stallHoldBytes", bif.DataOutBytes, 3'd4);
        checkVal("stallHoldLast", bif.DataOutLast, 0);
        bif.DataOutReady = 1'b1;
      end
    join
    drain("stall");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
